// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one single-port data RAM between an instruction-fetch requester
// (port 0, read-only) and a load/store requester (port 1, read or write).
// Each accepted request holds the RAM controls for WAIT_CYCLES cycles, then
// produces a one-cycle response pulse on the owning port. Port 1 normally has
// priority; after MAX_STARVE consecutive port-1 grants made while fetch was
// waiting, fetch is granted once.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req0_valid/addr/ready      fetch request handshake
//   rsp0_valid/data            fetch response pulse and held read data
//   req1_valid/we/addr/wdata/ready  load/store request handshake
//   rsp1_valid/data            load/store response (read data or write echo)
//   ram_address/read_en/write_en/data_in  registered RAM controls
//   ram_out                    RAM read data
//   busy                       high while an access is in flight
module ram_access_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_STARVE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    localparam logic [3:0] WAIT_INIT    = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    state_t            state_reg, state_next;
    logic [3:0]        wait_reg, wait_next;
    logic [3:0]        starve_reg, starve_next;
    logic              port_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;

    // The latched request address lives directly in ram_address_reg.
    logic [ADDR_W-1:0] ram_address_reg, ram_address_next;
    logic              ram_read_en_reg, ram_read_en_next;
    logic              ram_write_en_reg, ram_write_en_next;
    logic [DATA_W-1:0] ram_data_in_reg, ram_data_in_next;

    logic              rsp_valid_reg [2];
    logic [DATA_W-1:0] rsp_data_reg  [2];

    logic grant0, grant1, hs0, hs1, hs, capture;

    assign hs      = hs0 | hs1;
    assign capture = (state_reg == ST_ACCESS) && (wait_reg == 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, including the wait and starvation counters
    always_comb begin
        state_next  = state_reg;
        wait_next   = wait_reg;
        starve_next = starve_reg;
        case (state_reg)
            ST_IDLE: begin
                if (hs) begin
                    state_next = ST_ACCESS;
                    wait_next  = WAIT_INIT;
                    if (hs0) begin
                        starve_next = 4'd0;
                    end else if (req0_valid && starve_reg != 4'd15) begin
                        starve_next = starve_reg + 4'd1;
                    end
                end
            end
            ST_ACCESS: begin
                if (wait_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    wait_next = wait_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: grant, handshakes and next values of the RAM controls
    always_comb begin
        grant1     = req1_valid && !((starve_reg >= STARVE_LIMIT) && req0_valid);
        grant0     = req0_valid && !grant1;
        // Ready is masked during reset so no request looks accepted then.
        req0_ready = rst_n && (state_reg == ST_IDLE) && grant0;
        req1_ready = rst_n && (state_reg == ST_IDLE) && grant1;
        hs0        = req0_valid && req0_ready;
        hs1        = req1_valid && req1_ready;

        ram_address_next  = '0;
        ram_read_en_next  = 1'b0;
        ram_write_en_next = 1'b0;
        ram_data_in_next  = '0;
        if (hs) begin
            ram_address_next  = hs1 ? req1_addr : req0_addr;
            ram_read_en_next  = hs0 || !req1_we;
            ram_write_en_next = hs1 && req1_we;
            ram_data_in_next  = (hs1 && req1_we) ? req1_wdata : '0;
        end else if (state_reg == ST_ACCESS && wait_reg != 4'd0) begin
            // Hold controls until the final access cycle; they clear on the
            // edge that captures the response.
            ram_address_next  = ram_address_reg;
            ram_read_en_next  = ram_read_en_reg;
            ram_write_en_next = ram_write_en_reg;
            ram_data_in_next  = ram_data_in_reg;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_reg         <= 4'd0;
            starve_reg       <= 4'd0;
            port_reg         <= 1'b0;
            we_reg           <= 1'b0;
            wdata_reg        <= '0;
            ram_address_reg  <= '0;
            ram_read_en_reg  <= 1'b0;
            ram_write_en_reg <= 1'b0;
            ram_data_in_reg  <= '0;
        end else begin
            wait_reg         <= wait_next;
            starve_reg       <= starve_next;
            ram_address_reg  <= ram_address_next;
            ram_read_en_reg  <= ram_read_en_next;
            ram_write_en_reg <= ram_write_en_next;
            ram_data_in_reg  <= ram_data_in_next;
            if (hs) begin
                port_reg  <= hs1;
                we_reg    <= hs1 && req1_we;
                wdata_reg <= req1_wdata;
            end
        end
    end

    // Per-port response registers; data holds until that port's next response
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        localparam bit PORT_ID = (gi == 1);
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rsp_valid_reg[gi] <= 1'b0;
                rsp_data_reg[gi]  <= '0;
            end else begin
                rsp_valid_reg[gi] <= capture && (port_reg == PORT_ID);
                if (capture && (port_reg == PORT_ID)) begin
                    // Writes echo the stored data instead of reading it back.
                    rsp_data_reg[gi] <= we_reg ? wdata_reg : ram_out;
                end
            end
        end
    end

    assign rsp0_valid   = rsp_valid_reg[0];
    assign rsp0_data    = rsp_data_reg[0];
    assign rsp1_valid   = rsp_valid_reg[1];
    assign rsp1_data    = rsp_data_reg[1];
    assign ram_address  = ram_address_reg;
    assign ram_read_en  = ram_read_en_reg;
    assign ram_write_en = ram_write_en_reg;
    assign ram_data_in  = ram_data_in_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter. Instance 0 uses WAIT_CYCLES=1, instance 1
// uses WAIT_CYCLES=3; both use MAX_STARVE=4. Each instance has its own small
// RAM (indexed by address[3:0]) and a transaction-level reference memory.
module tb_ram_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n       [2];
    logic        req0_valid  [2];
    logic [63:0] req0_addr   [2];
    logic        req0_ready  [2];
    logic        rsp0_valid  [2];
    logic [63:0] rsp0_data   [2];
    logic        req1_valid  [2];
    logic        req1_we     [2];
    logic [63:0] req1_addr   [2];
    logic [63:0] req1_wdata  [2];
    logic        req1_ready  [2];
    logic        rsp1_valid  [2];
    logic [63:0] rsp1_data   [2];
    logic [63:0] ram_address [2];
    logic        ram_read_en [2];
    logic        ram_write_en[2];
    logic [63:0] ram_data_in [2];
    logic [63:0] ram_out     [2];
    logic        busy        [2];

    logic [63:0] dev_mem [2][16];
    logic [63:0] ref_mem [2][16];
    logic        mem_init = 1'b1;
    logic        mon_en   = 1'b0;
    int          exp_starve [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [63:0] init_word(input int a);
        return (a == 5) ? 64'h0000_0000_DEAD_BEEF : (64'hC0DE_0000_0000_0000 | 64'(a));
    endfunction

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ram_access_arbiter #(
            .ADDR_W(64), .DATA_W(64), .WAIT_CYCLES((gi == 0) ? 1 : 3), .MAX_STARVE(4)
        ) dut (
            .clk(clk), .rst_n(rst_n[gi]),
            .req0_valid(req0_valid[gi]), .req0_addr(req0_addr[gi]), .req0_ready(req0_ready[gi]),
            .rsp0_valid(rsp0_valid[gi]), .rsp0_data(rsp0_data[gi]),
            .req1_valid(req1_valid[gi]), .req1_we(req1_we[gi]), .req1_addr(req1_addr[gi]),
            .req1_wdata(req1_wdata[gi]), .req1_ready(req1_ready[gi]),
            .rsp1_valid(rsp1_valid[gi]), .rsp1_data(rsp1_data[gi]),
            .ram_address(ram_address[gi]), .ram_read_en(ram_read_en[gi]),
            .ram_write_en(ram_write_en[gi]), .ram_data_in(ram_data_in[gi]),
            .ram_out(ram_out[gi]), .busy(busy[gi])
        );
        assign ram_out[gi] = dev_mem[gi][ram_address[gi][3:0]];
    end

    // Behavioural RAM devices
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_init) begin
                for (int a = 0; a < 16; a++) dev_mem[i][a] <= init_word(a);
            end else if (ram_write_en[i]) begin
                dev_mem[i][ram_address[i][3:0]] <= ram_data_in[i];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Per-cycle safety properties
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("one_ready[%0d]", i), 64'(req0_ready[i] & req1_ready[i]), 64'd0);
                check($sformatf("rw_excl[%0d]", i), 64'(ram_read_en[i] & ram_write_en[i]), 64'd0);
            end
        end
    end

    task automatic check_all_zero(input int i, input string ph);
        check({ph, "_ready0"}, 64'(req0_ready[i]), 0);
        check({ph, "_ready1"}, 64'(req1_ready[i]), 0);
        check({ph, "_rsp0v"}, 64'(rsp0_valid[i]), 0);
        check({ph, "_rsp1v"}, 64'(rsp1_valid[i]), 0);
        check({ph, "_rsp0d"}, rsp0_data[i], 0);
        check({ph, "_rsp1d"}, rsp1_data[i], 0);
        check({ph, "_addr"}, ram_address[i], 0);
        check({ph, "_rd"}, 64'(ram_read_en[i]), 0);
        check({ph, "_wr"}, 64'(ram_write_en[i]), 0);
        check({ph, "_din"}, ram_data_in[i], 0);
        check({ph, "_busy"}, 64'(busy[i]), 0);
    endtask

    task automatic idle_inputs(input int i);
        req0_valid[i] = 1'b0; req1_valid[i] = 1'b0; req1_we[i] = 1'b0;
        req0_addr[i] = '0; req1_addr[i] = '0; req1_wdata[i] = '0;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic reset_inst(input int i, input int cycles);
        rst_n[i] = 1'b0;
        req0_valid[i] = 1'b1; req1_valid[i] = 1'b1;
        req0_addr[i] = {$urandom, $urandom}; req1_addr[i] = {$urandom, $urandom};
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            mon_en = 1'b1;
            @(negedge clk);
            check_all_zero(i, $sformatf("rst%0d", i));
        end
        rst_n[i] = 1'b1;
        idle_inputs(i);
        exp_starve[i] = 0;
        @(negedge clk);
        check($sformatf("post_rst_busy[%0d]", i), 64'(busy[i]), 0);
        $display("xact inst=%0d reset cycles=%0d", i, cycles);
    endtask

    // One isolated access; only one valid is raised, so it is granted at once.
    task automatic do_access(input int i, input int port, input bit we,
                             input logic [63:0] addr, input logic [63:0] wdata);
        int w;
        bit is_wr;
        logic [63:0] exp_data;
        w = wait_of(i);
        is_wr = (port == 1) && we;
        if (port == 0) begin
            req0_valid[i] = 1'b1; req0_addr[i] = addr;
        end else begin
            req1_valid[i] = 1'b1; req1_we[i] = we; req1_addr[i] = addr; req1_wdata[i] = wdata;
        end
        #1;
        check("grant0", 64'(req0_ready[i]), 64'(port == 0));
        check("grant1", 64'(req1_ready[i]), 64'(port == 1));
        exp_data = is_wr ? wdata : ref_mem[i][addr[3:0]];
        if (is_wr) ref_mem[i][addr[3:0]] = wdata;
        if (port == 0) exp_starve[i] = 0;
        @(posedge clk); #1;
        // Requester changes its inputs after the handshake; DUT must ignore them.
        req0_valid[i] = 1'b0; req1_valid[i] = 1'b0;
        req0_addr[i] = {$urandom, $urandom}; req1_addr[i] = {$urandom, $urandom};
        req1_wdata[i] = {$urandom, $urandom}; req1_we[i] = 1'($urandom);
        for (int c = 0; c < w; c++) begin
            @(negedge clk);
            check("acc_rd", 64'(ram_read_en[i]), 64'(!is_wr));
            check("acc_wr", 64'(ram_write_en[i]), 64'(is_wr));
            check("acc_addr", ram_address[i], addr);
            check("acc_din", ram_data_in[i], is_wr ? wdata : 64'd0);
            check("acc_busy", 64'(busy[i]), 1);
            check("acc_rspv", 64'({rsp0_valid[i], rsp1_valid[i]}), 0);
        end
        @(negedge clk);
        check("resp_v0", 64'(rsp0_valid[i]), 64'(port == 0));
        check("resp_v1", 64'(rsp1_valid[i]), 64'(port == 1));
        check("resp_data", (port == 0) ? rsp0_data[i] : rsp1_data[i], exp_data);
        check("resp_en", 64'({ram_read_en[i], ram_write_en[i]}), 0);
        check("resp_busy", 64'(busy[i]), 1);
        @(negedge clk);
        check("idle_busy", 64'(busy[i]), 0);
        check("idle_rspv", 64'({rsp0_valid[i], rsp1_valid[i]}), 0);
        check("hold_data", (port == 0) ? rsp0_data[i] : rsp1_data[i], exp_data);
        $display("xact inst=%0d port=%0d we=%0d addr=%h data=%h", i, port, is_wr, addr, exp_data);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            idle_inputs(i);
            exp_starve[i] = 0;
            for (int a = 0; a < 16; a++) ref_mem[i][a] = init_word(a);
        end
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        @(negedge clk);

        // Reset both instances with valids high
        fork
            reset_inst(0, 3);
            reset_inst(1, 3);
        join
        mem_init = 1'b0;

        // Directed: fetch of preloaded word, then store/load on port 1
        do_access(0, 0, 1'b0, 64'd5, 64'd0);
        do_access(0, 1, 1'b1, 64'd7, 64'h1234);
        do_access(0, 1, 1'b0, 64'd7, 64'd0);
        do_access(1, 1, 1'b1, 64'd7, 64'h1234);
        do_access(1, 1, 1'b0, 64'd7, 64'd0);
        do_access(1, 0, 1'b0, 64'hFFFF_0000_0000_0005, 64'd0);

        // Randomized accesses on both instances
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 25; n++) begin
                int p;
                p = int'($urandom_range(0, 1));
                do_access(i, p, (p == 1) ? 1'($urandom) : 1'b0,
                          {$urandom, $urandom}, {$urandom, $urandom});
            end
        end

        // Starvation guard on instance 0 with both valids held high
        reset_inst(0, 1);
        begin
            int grants;
            grants = 0;
            req0_valid[0] = 1'b1; req0_addr[0] = 64'd1;
            req1_valid[0] = 1'b1; req1_we[0] = 1'b0; req1_addr[0] = 64'd2;
            for (int c = 0; c < 80 && grants < 10; c++) begin
                #1;
                if (req0_ready[0] || req1_ready[0]) begin
                    int exp_g;
                    exp_g = (exp_starve[0] >= 4) ? 0 : 1;
                    check($sformatf("starve_grant%0d", grants), 64'(req1_ready[0]), 64'(exp_g));
                    $display("xact inst=0 starve grant=%0d port=%0d", grants, req1_ready[0]);
                    if (exp_g == 0) exp_starve[0] = 0;
                    else if (exp_starve[0] < 15) exp_starve[0]++;
                    grants++;
                end
                @(negedge clk);
            end
            check("starve_grant_count", 64'(grants), 64'd10);
            idle_inputs(0);
            for (int c = 0; c < 10 && busy[0]; c++) @(negedge clk);
            check("starve_drain", 64'(busy[0]), 0);
        end

        // Abort: reset in the second access cycle of a WAIT_CYCLES=3 read
        begin
            bit seen;
            seen = 1'b0;
            req1_valid[1] = 1'b1; req1_we[1] = 1'b0; req1_addr[1] = 64'd9;
            #1;
            check("abort_grant", 64'(req1_ready[1]), 1);
            @(posedge clk); #1;
            idle_inputs(1);
            @(negedge clk);
            check("abort_acc1_rd", 64'(ram_read_en[1]), 1);
            @(posedge clk); #1;
            rst_n[1] = 1'b0;
            @(negedge clk);
            check("abort_acc2_rd", 64'(ram_read_en[1]), 1);
            @(posedge clk); #1;
            rst_n[1] = 1'b1;
            @(negedge clk);
            check("abort_rd", 64'(ram_read_en[1]), 0);
            check("abort_wr", 64'(ram_write_en[1]), 0);
            check("abort_busy", 64'(busy[1]), 0);
            check("abort_addr", ram_address[1], 0);
            check("abort_rsp1d", rsp1_data[1], 0);
            for (int c = 0; c < 8; c++) begin
                if (rsp0_valid[1] || rsp1_valid[1]) seen = 1'b1;
                @(negedge clk);
            end
            check("abort_no_rsp", 64'(seen), 0);
            exp_starve[1] = 0;
            $display("xact inst=1 abort addr=%h", 64'd9);
        end

        // Instance 1 still works after the abort
        do_access(1, 1, 1'b0, 64'd7, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Sequences and shares the single-port 64-bit data RAM between two requesters.
- Port 0 is instruction fetch and is read-only. Port 1 is load/store and does reads or writes.
- Owns the RAM control pins (address, read_en, write_en, data_in) and guarantees that read_en and write_en are never asserted together.
- Adds valid/ready request handshakes, one-cycle response pulses, and a starvation guard for fetch.

Parameters:
- ADDR_W, 64, width of request and RAM address.
- DATA_W, 64, width of data.
- WAIT_CYCLES, 1, cycles the RAM controls are held before ram_out is captured. Legal range 1..15.
- MAX_STARVE, 4, consecutive port-1 grants with port 0 waiting before port 0 is forced. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  fetch read request.
- req0_addr  in  ADDR_W  fetch address.
- req0_ready  out  1  fetch request accepted this cycle.
- rsp0_valid  out  1  fetch response pulse.
- rsp0_data  out  DATA_W  fetch read data.
- req1_valid  in  1  load/store request.
- req1_we  in  1  1 = write, 0 = read.
- req1_addr  in  ADDR_W  load/store address.
- req1_wdata  in  DATA_W  store data.
- req1_ready  out  1  load/store request accepted this cycle.
- rsp1_valid  out  1  load/store response pulse.
- rsp1_data  out  DATA_W  read data, or echo of write data.
- ram_address  out  ADDR_W  to RAM address.
- ram_read_en  out  1  to RAM read_en.
- ram_write_en  out  1  to RAM write_en.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_out  in  DATA_W  from RAM out.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, wait counter=0, starve counter=0.
  - All outputs, including rsp*_data and the ram_* outputs, become 0.
  - Reset mid-operation aborts the access: no response is produced and the RAM enables drop at that edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Combinational grant: reqX_ready=1 only for the granted port, and only when that port's valid=1. At most one ready is high per cycle.
  - Grant rule: port 1 wins if req1_valid, unless starve>=MAX_STARVE and req0_valid, in which case port 0 wins.
  - On handshake (valid & ready), latch addr/we/wdata and the port id, set wait counter=WAIT_CYCLES-1, and move to ACCESS.
  - Starve counter increments (saturating at 15) when port 1 is granted while req0_valid=1. It clears when port 0 is granted.
  - ram_* outputs are 0.
- ACCESS:
  - ram_address = latched address.
  - Port 0, or port 1 with we=0: ram_read_en=1, ram_write_en=0.
  - Port 1 with we=1: ram_write_en=1, ram_read_en=0, ram_data_in = latched wdata.
  - ram_data_in=0 on reads.
  - All ram_* outputs are registered and stable for exactly WAIT_CYCLES cycles.
  - Wait counter decrements each cycle. At counter=0, capture ram_out into the responding port's rsp_data register and go to RESP.
  - For writes, capture the latched wdata (write-through echo).
- RESP:
  - ram_* outputs return to 0.
  - rsp_valid=1 for exactly one cycle on the owning port; the other port's rsp_valid stays 0.
  - Next state is IDLE.
  - rsp_data holds its value until that port's next response.
- Latency and throughput:
  - Handshake at edge N puts ram enables high from N+1. rsp_valid is high in cycle N+1+WAIT_CYCLES.
  - One access per WAIT_CYCLES+2 cycles; no overlap or pipelining.
- Requester rules:
  - A requester may drop valid before ready with no side effects.
  - Inputs are sampled only at the handshake edge; later changes to addr/wdata are ignored.
- Addresses pass through unchanged: no alignment or range checking.
- Reads and writes are never issued in the same cycle.
- busy=1 in ACCESS and RESP.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valids high -> all outputs 0 and both readys low throughout; after release, state=IDLE.
- Single fetch, WAIT_CYCLES=1, RAM preloaded data[5]=64'hDEAD_BEEF:
  - req0 addr=5 accepted at edge N.
  - ram_read_en=1 and ram_address=5 during cycle N+1.
  - rsp0_valid=1 with rsp0_data=64'hDEAD_BEEF in cycle N+2.
  - req0_ready low in cycles N+1..N+2.
- Store then load on port 1:
  - Write addr=7, wdata=64'h1234 -> ram_write_en=1 for one cycle, ram_read_en=0, rsp1_data=64'h1234.
  - Then read addr=7 -> rsp1_data=64'h1234.
- Starvation guard, MAX_STARVE=4: both valids held high continuously -> grant order 1,1,1,1,0,1,1,1,1,0; every cycle shows at most one ready and never read_en&write_en.
- WAIT_CYCLES=3: ram enables held exactly 3 cycles with a stable address, and rsp_valid lasts exactly 1 cycle. Changing req1_addr after the handshake does not change ram_address.
- Abort: assert rst_n=0 in the second ACCESS cycle (WAIT_CYCLES=3) -> ram enables 0 at the next edge, no rsp_valid ever, and busy=0.
